// File: rtl/boot_load_pkg.sv
// boot_load_pkg: shared states and default parameters of the boot loader
package boot_load_pkg;
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_ERROR} state_e;
    localparam int unsigned AddrWidthDef   = 12;
    localparam logic [31:0] EndMarkerDef   = 32'h0000_0FFF;
    localparam logic [15:0] ByteTimeoutDef = 16'd65535;
    localparam int unsigned ByteCntWidth   = 2;
endpackage

// File: rtl/boot_word_packer.sv
// boot_word_packer: packs four UART bytes little-endian into one 32-bit word
module boot_word_packer
    import boot_load_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    dv_i,
    input  logic [7:0]              byte_i,
    output logic [31:0]             word_o,
    output logic                    word_valid_o,
    output logic [ByteCntWidth-1:0] cnt_o
);
    logic [ByteCntWidth-1:0] r_cnt;
    logic [31:0]             r_buf;
    // bytes enter at the top and shift down, so the first byte ends in [7:0]
    assign word_o       = {byte_i, r_buf[31:8]};
    assign word_valid_o = dv_i && (&r_cnt);
    assign cnt_o        = r_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_buf <= '0;
        end else if (clr_i || word_valid_o) begin
            r_cnt <= '0;
            r_buf <= '0;
        end else if (dv_i) begin
            r_cnt <= r_cnt + 1'b1;
            r_buf <= word_o;
        end
    end
endmodule

// File: rtl/boot_load_sequencer.sv
// boot_load_sequencer: loads a program from UART or SPI into ICCM until an end marker
module boot_load_sequencer
    import boot_load_pkg::*;
#(
    parameter int unsigned AddrWidth   = AddrWidthDef,
    parameter logic [31:0] EndMarker   = EndMarkerDef,
    parameter logic [15:0] ByteTimeout = ByteTimeoutDef
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sel_i,
    input  logic                 uart_dv_i,
    input  logic [7:0]           uart_byte_i,
    input  logic                 spi_valid_i,
    input  logic [31:0]          spi_word_i,
    output logic                 mem_we_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic                 load_busy_o,
    output logic                 load_done_o,
    output logic                 load_err_o,
    output logic [AddrWidth:0]   word_count_o
);
    state_e                  r_state, w_next, w_cpl_next;
    logic                    r_sel;
    logic [AddrWidth-1:0]    r_addr;
    logic [AddrWidth:0]      r_count;
    logic [31:0]             r_wdata;
    logic [15:0]             r_to;
    logic                    w_sel, w_ustb, w_sstb, w_stb, w_accept, w_cpl, w_full, w_timeout;
    logic [31:0]             w_word, w_pk_word;
    logic                    w_pk_valid;
    logic [ByteCntWidth-1:0] w_pk_cnt;

    // in IDLE the live select decides which strobe starts the load
    assign w_sel      = (r_state == S_IDLE) ? sel_i : r_sel;
    assign w_ustb     = w_sel && uart_dv_i;
    assign w_sstb     = !w_sel && spi_valid_i;
    assign w_stb      = w_ustb || w_sstb;
    assign w_accept   = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign w_cpl      = w_accept && (w_sel ? w_pk_valid : w_sstb);
    assign w_word     = w_sel ? w_pk_word : spi_word_i;
    assign w_full     = r_count == {1'b1, {AddrWidth{1'b0}}};
    assign w_timeout  = (r_state == S_COLLECT) && (w_pk_cnt != '0) && (r_to == ByteTimeout);
    assign w_cpl_next = (w_word == EndMarker) ? S_DONE : (w_full ? S_ERROR : S_WRITE);

    boot_word_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       ((r_state == S_DONE) || (r_state == S_ERROR)),
        .dv_i        (w_accept && w_ustb),
        .byte_i      (uart_byte_i),
        .word_o      (w_pk_word),
        .word_valid_o(w_pk_valid),
        .cnt_o       (w_pk_cnt)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_COLLECT: w_next = w_cpl ? w_cpl_next : (w_stb ? S_COLLECT : (w_timeout ? S_ERROR : r_state));
            S_WRITE:           w_next = w_stb ? S_ERROR : (mem_gnt_i ? S_COLLECT : S_WRITE);
            default:           w_next = r_state;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
            r_wdata <= '0;
            r_to    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_stb) r_sel <= sel_i;
            if (w_accept && w_next == S_WRITE) r_wdata <= w_word;
            // the address saturates so a full memory never wraps back to 0
            if (r_state == S_WRITE && w_next == S_COLLECT) begin
                r_count <= r_count + 1'b1;
                r_addr  <= r_addr + AddrWidth'(!(&r_addr));
            end
            r_to <= (w_ustb || r_state != S_COLLECT || w_pk_cnt == '0) ? 16'd0 : r_to + 16'd1;
        end
    end

    assign mem_we_o     = r_state == S_WRITE;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign load_busy_o  = (r_state == S_COLLECT) || (r_state == S_WRITE);
    assign load_done_o  = r_state == S_DONE;
    assign load_err_o   = r_state == S_ERROR;
    assign word_count_o = r_count;
endmodule

// File: tb/tb_boot_load_sequencer.sv
// tb_boot_load_sequencer: scoreboard bench for the boot loader, default and 2-bit address builds
module tb_boot_load_sequencer;
    import boot_load_pkg::*;

    logic        clk_i = 1'b0, rst_ni = 1'b0, sel_i = 1'b0;
    logic        uart_dv_i = 1'b0, spi_valid_i = 1'b0, mem_gnt_i = 1'b1, c_spi_valid = 1'b0;
    logic [7:0]  uart_byte_i = '0;
    logic [31:0] spi_word_i = '0, c_spi_word = '0;
    logic        mem_we_o, load_busy_o, load_done_o, load_err_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [12:0] word_count_o;
    logic        c_we, c_busy, c_done, c_err;
    logic [1:0]  c_addr;
    logic [31:0] c_wdata;
    logic [2:0]  c_count;
    int          n_checks = 0, n_errors = 0;
    logic [63:0] sb_q[$], sbc_q[$];
    logic [63:0] exp_w, exp_c;
    logic [7:0]  ub[12] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00};
    logic [7:0]  fb[4]  = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};

    always #5 clk_i = ~clk_i;

    boot_load_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sel_i(sel_i),
        .uart_dv_i(uart_dv_i), .uart_byte_i(uart_byte_i),
        .spi_valid_i(spi_valid_i), .spi_word_i(spi_word_i),
        .mem_we_o(mem_we_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .load_busy_o(load_busy_o), .load_done_o(load_done_o), .load_err_o(load_err_o),
        .word_count_o(word_count_o)
    );

    boot_load_sequencer #(.AddrWidth(2)) dut_cap (
        .clk_i(clk_i), .rst_ni(rst_ni), .sel_i(1'b0),
        .uart_dv_i(1'b0), .uart_byte_i(8'h00),
        .spi_valid_i(c_spi_valid), .spi_word_i(c_spi_word),
        .mem_we_o(c_we), .mem_gnt_i(1'b1), .mem_addr_o(c_addr), .mem_wdata_o(c_wdata),
        .load_busy_o(c_busy), .load_done_o(c_done), .load_err_o(c_err),
        .word_count_o(c_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // granted writes are compared against the expected {addr, data} in order
    always @(negedge clk_i) begin
        if (rst_ni && mem_we_o && mem_gnt_i) begin
            if (sb_q.size() == 0) check("unexpected_write", {32'(mem_addr_o), mem_wdata_o}, 64'h0);
            else begin
                exp_w = sb_q.pop_front();
                check("wr_addr", 64'(mem_addr_o), 64'(exp_w[63:32]));
                check("wr_data", 64'(mem_wdata_o), 64'(exp_w[31:0]));
            end
        end
        if (rst_ni && c_we) begin
            if (sbc_q.size() == 0) check("cap_unexpected_write", {32'(c_addr), c_wdata}, 64'h0);
            else begin
                exp_c = sbc_q.pop_front();
                check("cap_wr_addr", 64'(c_addr), 64'(exp_c[63:32]));
                check("cap_wr_data", 64'(c_wdata), 64'(exp_c[31:0]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        uart_byte_i = b;
        uart_dv_i   = 1'b1;
        idle(1);
        uart_dv_i   = 1'b0;
        spi_valid_i = 1'b0;
        idle(gap);
    endtask

    task automatic send_spi(input logic [31:0] w, input int gap);
        spi_word_i  = w;
        spi_valid_i = 1'b1;
        idle(1);
        spi_valid_i = 1'b0;
        idle(gap);
    endtask

    task automatic send_cap(input logic [31:0] w);
        c_spi_word  = w;
        c_spi_valid = 1'b1;
        idle(1);
        c_spi_valid = 1'b0;
        idle(2);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #2;
        check("rst_we", 64'(mem_we_o), 64'h0);
        check("rst_addr", 64'(mem_addr_o), 64'h0);
        check("rst_wdata", 64'(mem_wdata_o), 64'h0);
        check("rst_busy", 64'(load_busy_o), 64'h0);
        check("rst_done", 64'(load_done_o), 64'h0);
        check("rst_err", 64'(load_err_o), 64'h0);
        check("rst_count", 64'(word_count_o), 64'h0);
        check("rst_cap_err", 64'(c_err), 64'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        idle(1);
    endtask

    initial begin
        #1;
        do_reset();

        // UART load; a simultaneous SPI marker strobe must be ignored
        sel_i = 1'b1;
        sb_q.push_back({32'd0, 32'h0000_0013});
        sb_q.push_back({32'd1, 32'h0010_0093});
        spi_word_i  = EndMarkerDef;
        spi_valid_i = 1'b1;
        foreach (ub[i]) send_byte(ub[i], 2);
        check("uart_done", 64'(load_done_o), 64'h1);
        check("uart_err", 64'(load_err_o), 64'h0);
        check("uart_busy", 64'(load_busy_o), 64'h0);
        check("uart_count", 64'(word_count_o), 64'd2);
        check("uart_sb_empty", 64'(sb_q.size()), 64'h0);
        for (int i = 0; i < 4; i++) send_byte(8'h55, 1);
        check("done_terminal_count", 64'(word_count_o), 64'd2);
        check("done_terminal_flag", 64'(load_done_o), 64'h1);
        do_reset();

        // SPI load with a 3-cycle grant stall; later sel_i change is ignored
        sel_i     = 1'b0;
        mem_gnt_i = 1'b0;
        sb_q.push_back({32'd0, 32'hDEAD_BEEF});
        send_spi(32'hDEAD_BEEF, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("stall_we", 64'(mem_we_o), 64'h1);
            check("stall_addr", 64'(mem_addr_o), 64'h0);
            check("stall_data", 64'(mem_wdata_o), 64'hDEAD_BEEF);
            @(posedge clk_i);
            #1;
        end
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        check("stall_we_4th", 64'(mem_we_o), 64'h1);
        idle(1);
        check("stall_we_after", 64'(mem_we_o), 64'h0);
        sel_i = 1'b1;
        send_spi(EndMarkerDef, 2);
        check("spi_done", 64'(load_done_o), 64'h1);
        check("spi_count", 64'(word_count_o), 64'd1);
        check("spi_addr", 64'(mem_addr_o), 64'd1);
        check("spi_sb_empty", 64'(sb_q.size()), 64'h0);
        do_reset();

        // UART timeout after two bytes
        sel_i = 1'b1;
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        repeat (65535) @(posedge clk_i);
        #1;
        check("to_not_yet", 64'(load_err_o), 64'h0);
        check("to_busy", 64'(load_busy_o), 64'h1);
        idle(1);
        check("to_err", 64'(load_err_o), 64'h1);
        check("to_done", 64'(load_done_o), 64'h0);
        check("to_count", 64'(word_count_o), 64'h0);
        do_reset();

        // overrun: second SPI word while the first write is not granted
        sel_i     = 1'b0;
        mem_gnt_i = 1'b0;
        send_spi(32'h0000_0011, 1);
        check("ovr_we_pending", 64'(mem_we_o), 64'h1);
        send_spi(32'h0000_0022, 0);
        @(negedge clk_i);
        check("ovr_err", 64'(load_err_o), 64'h1);
        check("ovr_we", 64'(mem_we_o), 64'h0);
        check("ovr_count", 64'(word_count_o), 64'h0);
        mem_gnt_i = 1'b1;

        // capacity on the 2-bit address build
        for (int i = 0; i < 4; i++) begin
            sbc_q.push_back({32'(i), 32'h100 + 32'(i)});
            send_cap(32'h100 + 32'(i));
        end
        check("cap_count_full", 64'(c_count), 64'd4);
        check("cap_no_err_yet", 64'(c_err), 64'h0);
        send_cap(32'h999);
        check("cap_err", 64'(c_err), 64'h1);
        check("cap_count", 64'(c_count), 64'd4);
        check("cap_sb_empty", 64'(sbc_q.size()), 64'h0);
        do_reset();

        // reset mid-word abandons the partial word
        sel_i = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'h77, 1);
        check("mid_busy", 64'(load_busy_o), 64'h1);
        do_reset();
        sb_q.push_back({32'd0, 32'hCAFE_F00D});
        foreach (fb[i]) send_byte(fb[i], 2);
        check("fresh_count", 64'(word_count_o), 64'd1);
        check("fresh_sb_empty", 64'(sb_q.size()), 64'h0);
        check("fresh_err", 64'(load_err_o), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
